// File: rtl/phy_lane_scheduler.sv
// rtl/phy_lane_scheduler.sv - round-robin burst scheduler sharing one PHY byte slot among four lanes
module phy_lane_scheduler #(
    parameter int          BURST_LEN = 4,
    parameter logic [7:0]  IDLE_SYM  = 8'hBC
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] data_in0,
    input  logic [7:0] data_in1,
    input  logic [7:0] data_in2,
    input  logic [7:0] data_in3,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       valid2,
    input  logic       valid3,
    output logic       ready0,
    output logic       ready1,
    output logic       ready2,
    output logic       ready3,
    input  logic       out_ready,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [1:0] lane_id,
    output logic       sof_out
);

    localparam int            CW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    grant;
    logic [1:0]    grant_nxt;
    logic [1:0]    last_grant;
    logic [1:0]    last_grant_nxt;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] beat_nxt;

    logic [3:0]    valid_vec;
    logic [7:0]    data_vec [4];
    logic [1:0]    sel;
    logic [1:0]    cand;
    logic          any_valid;
    logic          xfer;

    assign valid_vec   = {valid3, valid2, valid1, valid0};
    assign data_vec[0] = data_in0;
    assign data_vec[1] = data_in1;
    assign data_vec[2] = data_in2;
    assign data_vec[3] = data_in3;
    assign any_valid   = |valid_vec;

    // A byte moves only when the granted lane is valid and downstream can take it.
    assign xfer   = (state == S_GRANT) && out_ready && valid_vec[grant];

    assign ready0 = (state == S_GRANT) && (grant == 2'd0) && out_ready;
    assign ready1 = (state == S_GRANT) && (grant == 2'd1) && out_ready;
    assign ready2 = (state == S_GRANT) && (grant == 2'd2) && out_ready;
    assign ready3 = (state == S_GRANT) && (grant == 2'd3) && out_ready;

    // Round-robin pick: scan from the farthest offset down so the nearest valid lane after last_grant wins.
    always_comb begin
        sel  = last_grant + 2'd1;
        cand = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            cand = last_grant + 2'(i);
            if (valid_vec[cand]) begin
                sel = cand;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats in GRANT only while downstream is ready.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        beat_nxt       = beat_cnt;
        case (state)
            S_IDLE: begin
                if (any_valid) begin
                    state_nxt      = S_GRANT;
                    grant_nxt      = sel;
                    last_grant_nxt = sel;
                    beat_nxt       = '0;
                end
            end
            S_GRANT: begin
                if (out_ready) begin
                    if (xfer) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state_nxt = S_IDLE;
                            beat_nxt  = '0;
                        end else begin
                            beat_nxt  = beat_cnt + CW'(1);
                        end
                    end else begin
                        state_nxt = S_IDLE;
                        beat_nxt  = '0;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                beat_nxt  = '0;
            end
        endcase
    end

    // State register; reset points last_grant at lane 3 so lane 0 wins first.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state      <= S_IDLE;
            grant      <= 2'd0;
            last_grant <= 2'd3;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_nxt;
        end
    end

    // Output byte register: advances only when downstream is ready, idle symbol fills empty slots.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            data_out  <= IDLE_SYM;
            valid_out <= 1'b0;
            lane_id   <= 2'd0;
            sof_out   <= 1'b0;
        end else if (out_ready) begin
            if (xfer) begin
                data_out  <= data_vec[grant];
                valid_out <= 1'b1;
                lane_id   <= grant;
                sof_out   <= (beat_cnt == '0);
            end else begin
                data_out  <= IDLE_SYM;
                valid_out <= 1'b0;
                sof_out   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_phy_lane_scheduler.sv
// tb/tb_phy_lane_scheduler.sv - scoreboard bench for phy_lane_scheduler with a lane-level reference model
module tb_phy_lane_scheduler;

    localparam int BL = 4;

    logic       clk_4f = 1'b0;
    logic       reset;
    logic [7:0] din [4];
    logic [3:0] vin;
    logic       out_ready;
    logic       ready0, ready1, ready2, ready3;
    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] lane_id;
    logic       sof_out;

    int checks = 0;
    int errors = 0;

    // Reference model: which lane owns the slot, how many bytes it has sent, who was served last.
    bit         m_known  = 1'b0;
    bit         m_active;
    int         m_lane;
    int         m_sent;
    int         m_last;
    logic [7:0] m_data;
    bit         m_valid;
    logic [1:0] m_lid;
    bit         m_sof;
    int         pend_lane = -1;

    logic [11:0] exp_q [$];
    logic [11:0] mon_exp;

    phy_lane_scheduler #(.BURST_LEN(BL), .IDLE_SYM(8'hBC)) dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .data_in0  (din[0]),
        .data_in1  (din[1]),
        .data_in2  (din[2]),
        .data_in3  (din[3]),
        .valid0    (vin[0]),
        .valid1    (vin[1]),
        .valid2    (vin[2]),
        .valid3    (vin[3]),
        .ready0    (ready0),
        .ready1    (ready1),
        .ready2    (ready2),
        .ready3    (ready3),
        .out_ready (out_ready),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lane_id   (lane_id),
        .sof_out   (sof_out)
    );

    always #5 clk_4f = ~clk_4f;

    // Monitor: every edge the DUT output register must match the oldest predicted slot.
    always @(posedge clk_4f) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            checks++;
            if ({data_out, valid_out, lane_id, sof_out} !== mon_exp) begin
                errors++;
                $display("FAIL out_slot t=%0t got data=%h valid=%b lane=%0d sof=%b exp data=%h valid=%b lane=%0d sof=%b",
                         $time, data_out, valid_out, lane_id, sof_out,
                         mon_exp[11:4], mon_exp[3], mon_exp[2:1], mon_exp[0]);
            end
        end
    end

    // One byte slot: drive inputs, check ready, predict the next output slot, advance to the next negedge.
    task automatic step(input bit rst, input logic [3:0] v, input bit ordy);
        logic [3:0] exp_rdy;
        bit         x;
        bit         found;
        int         cand;
        if (pend_lane >= 0) begin
            din[pend_lane] = din[pend_lane] + 8'd1;
            pend_lane = -1;
        end
        vin       = v;
        out_ready = ordy;
        reset     = rst;
        #1;
        if (m_known) begin
            exp_rdy = (m_active && ordy) ? (4'b0001 << m_lane) : 4'b0000;
            checks++;
            if ({ready3, ready2, ready1, ready0} !== exp_rdy) begin
                errors++;
                $display("FAIL ready t=%0t got %b exp %b", $time, {ready3, ready2, ready1, ready0}, exp_rdy);
            end
        end
        if (rst) begin
            m_known  = 1'b1;
            m_active = 1'b0;
            m_lane   = 0;
            m_sent   = 0;
            m_last   = 3;
            m_data   = 8'hBC;
            m_valid  = 1'b0;
            m_lid    = 2'd0;
            m_sof    = 1'b0;
        end else begin
            x = m_active && ordy && v[m_lane];
            if (ordy) begin
                if (x) begin
                    m_data  = din[m_lane];
                    m_valid = 1'b1;
                    m_lid   = 2'(m_lane);
                    m_sof   = (m_sent == 0);
                end else begin
                    m_data  = 8'hBC;
                    m_valid = 1'b0;
                    m_sof   = 1'b0;
                end
            end
            if (!m_active) begin
                found = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    cand = (m_last + k) % 4;
                    if (!found && v[cand]) begin
                        found    = 1'b1;
                        m_active = 1'b1;
                        m_lane   = cand;
                        m_last   = cand;
                        m_sent   = 0;
                    end
                end
            end else if (ordy) begin
                if (x) begin
                    m_sent++;
                    if (m_sent == BL) begin
                        m_active = 1'b0;
                        m_sent   = 0;
                    end
                end else begin
                    m_active = 1'b0;
                    m_sent   = 0;
                end
            end
            if (x) pend_lane = m_lane;
        end
        exp_q.push_back({m_data, m_valid, m_lid, m_sof});
        @(negedge clk_4f);
    endtask

    initial begin
        bit hit;
        din[0] = 8'hEE;
        din[1] = 8'h01;
        din[2] = 8'hFF;
        din[3] = 8'hFD;
        vin       = 4'b0000;
        out_ready = 1'b1;
        reset     = 1'b1;

        // Reset held with nothing valid.
        repeat (2) step(1'b1, 4'b0000, 1'b1);

        // All lanes valid, downstream always ready: strict 0,1,2,3 rotation of full bursts.
        repeat (40) step(1'b0, 4'b1111, 1'b1);

        // Only lane 2 requests.
        din[2] = 8'h10;
        repeat (20) step(1'b0, 4'b0100, 1'b1);

        // Randomised valid and back-pressure.
        for (int n = 0; n < 1500; n++) begin
            step(1'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end

        // Long stalls while the granted lane toggles valid.
        for (int n = 0; n < 300; n++) begin
            step(1'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a lane-3 burst, then all lanes valid again.
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            if (m_active && m_lane == 3 && m_sent >= 1) begin
                hit = 1'b1;
            end else begin
                step(1'b0, 4'b1111, 1'b1);
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL lane3_midburst_reached got none exp a lane-3 burst within 200 cycles");
        end
        step(1'b1, 4'b1111, 1'b1);
        repeat (25) step(1'b0, 4'b1111, 1'b1);

        repeat (3) step(1'b0, 4'b0000, 1'b1);
        @(posedge clk_4f);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
